anc_frame_sched: RTL

ANC_FRAME_SCHED -- requirements
Module: anc_frame_sched

---
 rtl/anc_pkg.sv | 29 ++
 rtl/anc_tick_pend.sv | 65 ++++++
 rtl/anc_frame_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/anc_pkg.sv
// Shared definitions for the ANC frame scheduler.
//   - one-hot scheduler state encodings
//   - scheduler mode codes (offline Sz fit vs online ANC)
//   - default pass timeout and overrun counter width
// Compile-time option: ANC_OFZ_EN selects whether the offline-fit phase exists;
// it sets the mode the scheduler comes out of reset in.
package anc_pkg;

  localparam int unsigned TMO_CYC_DEF = 1023;
  localparam int unsigned OVR_W_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'h1,
    S_OFZ  = 3'h2,
    S_ANC  = 3'h4
  } state_t;

  typedef enum logic {
    MODE_OFZ = 1'b0,
    MODE_ANC = 1'b1
  } mode_t;

`ifdef ANC_OFZ_EN
  localparam mode_t MODE_RST = MODE_OFZ;
`else
  localparam mode_t MODE_RST = MODE_ANC;
`endif

endpackage

// File: rtl/anc_tick_pend.sv
// Sample-tick bookkeeping for the ANC frame scheduler.
// Holds at most one waiting tick and counts ticks that arrive while one is
// already waiting (lost ticks).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        level; 0 = sample_tick ignored
//   sample_tick   one-cycle strobe per audio sample
//   issue         a start pulse is being issued this cycle (consumes the wait)
//   clr_err       one-cycle pulse; clears overrun / ovr_cnt
//   pending       a tick is waiting for a start
//   overrun       sticky lost-tick flag
//   ovr_cnt       saturating lost-tick count
module anc_tick_pend #(
  parameter int unsigned OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sample_tick,
  input  logic             issue,
  input  logic             clr_err,
  output logic             pending,
  output logic             overrun,
  output logic [OVR_W-1:0] ovr_cnt
);

  logic tick_v;
  logic lost;

  assign tick_v = enable & sample_tick;
  // A tick arriving while another is still waiting is lost; the waiting slot
  // stays occupied even if the older tick is consumed by a start this cycle.
  assign lost   = tick_v & pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (lost) begin
      pending <= 1'b1;
    end else if (issue) begin
      pending <= 1'b0;
    end else if (tick_v) begin
      pending <= 1'b1;
    end
  end

  // A lost tick in the same cycle as clr_err wins: flag set, count restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      ovr_cnt <= '0;
    end else if (lost) begin
      overrun <= 1'b1;
      if (clr_err) begin
        ovr_cnt <= OVR_W'(1);
      end else if (ovr_cnt != '1) begin
        ovr_cnt <= ovr_cnt + OVR_W'(1);
      end
    end else if (clr_err) begin
      overrun <= 1'b0;
      ovr_cnt <= '0;
    end
  end

endmodule

// File: rtl/anc_frame_sched.sv
// ANC frame scheduler: turns per-sample ticks into one start pulse per audio
// sample, first for the offline secondary-path (Sz) fit and, once that fit
// reports ofz_ok, for the online ANC filter. Each pass is guarded by a
// timeout; ticks arriving faster than passes complete are counted as lost.
// Compile-time option: ANC_OFZ_EN
//   defined   -> offline-fit phase runs first, online resets to 0
//   undefined -> online resets to 1, ofz_start tied 0, ofz_ok/ofz_done ignored
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        level; 0 = ignore sample_tick (outstanding pass still finishes)
//   sample_tick   one-cycle strobe per audio sample
//   ofz_ok        level; offline Sz identification complete
//   ofz_done      pulse; offline-fit pass finished
//   anc_done      pulse; online ANC pass finished
//   clr_err       pulse; clears overrun, ovr_cnt, timeout
//   ofz_start     pulse; launch offline-fit pass
//   anc_start     pulse; launch online ANC pass
//   online        0 = offline-fit mode, 1 = online ANC mode
//   busy          a pass is outstanding
//   overrun       sticky; a tick was lost
//   ovr_cnt       saturating lost-tick count
//   timeout       sticky; a pass exceeded TMO_CYC cycles
module anc_frame_sched
  import anc_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEF,
  parameter int unsigned OVR_W   = OVR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sample_tick,
  input  logic             ofz_ok,
  input  logic             ofz_done,
  input  logic             anc_done,
  input  logic             clr_err,
  output logic             ofz_start,
  output logic             anc_start,
  output logic             online,
  output logic             busy,
  output logic             overrun,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic             timeout
);

  localparam int unsigned TMR_W = $clog2(TMO_CYC + 1);

  state_t           state_q;
  state_t           state_d;
  mode_t            mode_q;
  logic [TMR_W-1:0] timer_q;
  logic             tick_v;
  logic             pending;
  logic             issue;
  logic             tmo_hit;
  logic             tmr_lim;
  logic             ofz_ok_i;
  logic             ofz_done_i;
  logic             anc_start_q;
  logic             timeout_q;

`ifdef ANC_OFZ_EN
  logic ofz_start_q;

  assign ofz_ok_i   = ofz_ok;
  assign ofz_done_i = ofz_done;
`else
  logic unused_ofz;

  assign ofz_ok_i   = 1'b0;
  assign ofz_done_i = 1'b0;
  assign unused_ofz = ofz_ok ^ ofz_done;
`endif

  assign tick_v  = enable & sample_tick;
  assign tmr_lim = (timer_q == TMR_W'(TMO_CYC));

  anc_tick_pend #(
    .OVR_W (OVR_W)
  ) u_tick_pend (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sample_tick (sample_tick),
    .issue       (issue),
    .clr_err     (clr_err),
    .pending     (pending),
    .overrun     (overrun),
    .ovr_cnt     (ovr_cnt)
  );

  // Next state. A done pulse takes priority over the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending || tick_v) begin
          issue   = 1'b1;
          state_d = (mode_q == MODE_ANC) ? S_ANC : S_OFZ;
        end
      end
      S_OFZ: begin
        if (ofz_done_i) begin
          state_d = S_IDLE;
        end else if (tmr_lim) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ANC: begin
        if (anc_done) begin
          state_d = S_IDLE;
        end else if (tmr_lim) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer reads 0 in the cycle the start pulse is visible and counts the
  // cycles of the pass from there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      mode_q      <= MODE_RST;
      anc_start_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue || state_d == S_IDLE) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TMR_W'(1);
      end
      if (state_q == S_IDLE && ofz_ok_i) begin
        mode_q <= MODE_ANC;
      end
      anc_start_q <= issue && (mode_q == MODE_ANC);
      if (tmo_hit) begin
        timeout_q <= 1'b1;
      end else if (clr_err) begin
        timeout_q <= 1'b0;
      end
    end
  end

`ifdef ANC_OFZ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofz_start_q <= 1'b0;
    end else begin
      ofz_start_q <= issue && (mode_q == MODE_OFZ);
    end
  end

  assign ofz_start = ofz_start_q;
`else
  assign ofz_start = 1'b0;
`endif

  assign anc_start = anc_start_q;
  assign online    = (mode_q == MODE_ANC);
  assign busy      = (state_q != S_IDLE);
  assign timeout   = timeout_q;

endmodule
